// File: rtl/sram_arb_ctl_if.sv
// Request/response and ZBT pin bundle shared by sram_arb_ctl and its requesters.
// Latency: none, wires only.
// Backpressure: per-port valid/ready on requests; responses and SRAM pins are never stalled.
interface sram_arb_ctl_if #(
  parameter int NPORTS = 4,
  parameter int AW     = 18,
  parameter int DW     = 32,
  parameter int PAW    = 16
);
  localparam int BW = DW / 8;

  // Request side, one slice per port
  logic [NPORTS*PAW-1:0] i_req_adr;
  logic [NPORTS-1:0]     i_req_we;
  logic [NPORTS*DW-1:0]  i_req_wdata;
  logic [NPORTS*BW-1:0]  i_req_be;
  logic [NPORTS-1:0]     i_req_valid;
  logic [NPORTS-1:0]     o_req_ready;

  // Read responses, one slice per port
  logic [NPORTS*DW-1:0]  o_resp_rdata;
  logic [NPORTS-1:0]     o_resp_valid;

  // ZBT pins (split data bus, tristate lives in the pad wrapper)
  logic [AW-1:0]         o_sram_adr;
  logic [BW-1:0]         o_sram_bw_n;
  logic                  o_sram_we_n;
  logic                  o_sram_en_n;
  logic [DW-1:0]         o_sram_dq;
  logic                  o_sram_dq_oe;
  logic [DW-1:0]         i_sram_dq;

  // Controller side
  modport slave (
    input  i_req_adr, i_req_we, i_req_wdata, i_req_be, i_req_valid, i_sram_dq,
    output o_req_ready, o_resp_rdata, o_resp_valid,
    output o_sram_adr, o_sram_bw_n, o_sram_we_n, o_sram_en_n, o_sram_dq, o_sram_dq_oe
  );

  // Requester / pad side
  modport master (
    output i_req_adr, i_req_we, i_req_wdata, i_req_be, i_req_valid, i_sram_dq,
    input  o_req_ready, o_resp_rdata, o_resp_valid,
    input  o_sram_adr, o_sram_bw_n, o_sram_we_n, o_sram_en_n, o_sram_dq, o_sram_dq_oe
  );
endinterface

// File: rtl/sram_arb_ctl.sv
// N-port round-robin front-end driving pipelined ZBT SRAM pins, per-port read return.
// Latency: pins 1 cycle after accept, write data RD/WR_LAT later, read data RD_LAT+2 after accept.
// Backpressure: one ready per cycle to the round-robin winner; response path cannot stall.
module sram_arb_ctl #(
  parameter int NPORTS    = 4,
  parameter int AW        = 18,
  parameter int DW        = 32,
  parameter int PARTITION = 1,
  parameter int PAW       = 16,
  parameter int RD_LAT    = 4,
  parameter int WR_LAT    = 2,
  parameter int RESP_HOLD = 1
) (
  input  logic          clk_sram,
  input  logic          rst_sram,
  sram_arb_ctl_if.slave bus
);
  localparam int BW  = DW / 8;
  localparam int PW  = (NPORTS > 1) ? $clog2(NPORTS) : 0;
  // Keep a 1-bit id vector even for a single port so the arithmetic stays uniform
  localparam int IDW = (NPORTS > 1) ? PW : 1;

  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    ptr_nxt;
  logic [IDW-1:0]    grant_id;
  logic              grant_vld;
  logic [NPORTS-1:0] grant_oh;
  int                scan_idx;

  logic [PAW-1:0]    sel_adr;
  logic              sel_we;
  logic [DW-1:0]     sel_wdata;
  logic [BW-1:0]     sel_be;
  logic [AW-1:0]     map_adr;

  logic [AW-1:0]     sram_adr_q;
  logic [BW-1:0]     sram_bw_n_q;
  logic              sram_we_n_q;
  logic              sram_en_n_q;
  logic [DW-1:0]     sram_dq_q;
  logic              sram_dq_oe_q;

  logic              wp_vld_q [WR_LAT];
  logic [DW-1:0]     wp_dat_q [WR_LAT];

  logic [NPORTS-1:0] iss_tag_q;
  logic [NPORTS-1:0] rtag_q [RD_LAT];

  logic [DW-1:0]     resp_dat_q [NPORTS];
  logic [NPORTS-1:0] resp_vld_q;
  logic [2:0]        hold_cnt_q [NPORTS];

  // Work-conserving scan: first valid port at or after the pointer wins
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = 0;
    for (int i = 0; i < NPORTS; i++) begin
      scan_idx = (int'(ptr_q) + i) % NPORTS;
      if (!grant_vld && bus.i_req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(scan_idx);
      end
    end
  end

  // One-hot ready to the winner, held low while reset is asserted
  always_comb begin
    grant_oh = '0;
    if (grant_vld && !rst_sram) begin
      grant_oh[grant_id] = 1'b1;
    end
  end

  assign bus.o_req_ready = grant_oh;

  assign sel_adr   = bus.i_req_adr[int'(grant_id)*PAW +: PAW];
  assign sel_we    = bus.i_req_we[grant_id];
  assign sel_wdata = bus.i_req_wdata[int'(grant_id)*DW +: DW];
  assign sel_be    = bus.i_req_be[int'(grant_id)*BW +: BW];

  assign ptr_nxt = (int'(grant_id) == NPORTS - 1) ? '0 : IDW'(int'(grant_id) + 1);

  // Partitioned mode gives every port its own slice of the SRAM
  if (PARTITION != 0 && NPORTS > 1) begin : g_part
    assign map_adr = {grant_id, sel_adr};
  end else begin : g_flat
    assign map_adr = sel_adr;
  end

  // Round-robin pointer moves past the winner; untouched when nobody asks
  always_ff @(posedge clk_sram or posedge rst_sram) begin
    if (rst_sram) begin
      ptr_q <= '0;
    end else if (grant_vld) begin
      ptr_q <= ptr_nxt;
    end
  end

  // Issue stage: register command pins and the read tag for the accepted request
  always_ff @(posedge clk_sram or posedge rst_sram) begin
    if (rst_sram) begin
      sram_adr_q  <= '0;
      sram_bw_n_q <= '1;
      sram_we_n_q <= 1'b1;
      sram_en_n_q <= 1'b1;
      iss_tag_q   <= '0;
    end else if (grant_vld) begin
      sram_adr_q  <= map_adr;
      sram_bw_n_q <= sel_we ? ~sel_be : '1;
      sram_we_n_q <= ~sel_we;
      sram_en_n_q <= 1'b0;
      iss_tag_q   <= sel_we ? '0 : grant_oh;
    end else begin
      sram_bw_n_q <= '1;
      sram_we_n_q <= 1'b1;
      sram_en_n_q <= 1'b1;
      iss_tag_q   <= '0;
    end
  end

  // Write data delay line; stage 0 lines up with the command cycle
  always_ff @(posedge clk_sram or posedge rst_sram) begin
    if (rst_sram) begin
      for (int k = 0; k < WR_LAT; k++) begin
        wp_vld_q[k] <= 1'b0;
        wp_dat_q[k] <= '0;
      end
    end else begin
      wp_vld_q[0] <= grant_vld && sel_we;
      wp_dat_q[0] <= sel_wdata;
      for (int k = 1; k < WR_LAT; k++) begin
        wp_vld_q[k] <= wp_vld_q[k-1];
        wp_dat_q[k] <= wp_dat_q[k-1];
      end
    end
  end

  // Drive the data pins for exactly one cycle, WR_LAT after the command
  always_ff @(posedge clk_sram or posedge rst_sram) begin
    if (rst_sram) begin
      sram_dq_q    <= '0;
      sram_dq_oe_q <= 1'b0;
    end else if (wp_vld_q[WR_LAT-1]) begin
      sram_dq_q    <= wp_dat_q[WR_LAT-1];
      sram_dq_oe_q <= 1'b1;
    end else begin
      sram_dq_q    <= '0;
      sram_dq_oe_q <= 1'b0;
    end
  end

  // Read tag shift register; last stage marks the cycle the pad carries read data
  always_ff @(posedge clk_sram or posedge rst_sram) begin
    if (rst_sram) begin
      for (int k = 0; k < RD_LAT; k++) begin
        rtag_q[k] <= '0;
      end
    end else begin
      rtag_q[0] <= iss_tag_q;
      for (int k = 1; k < RD_LAT; k++) begin
        rtag_q[k] <= rtag_q[k-1];
      end
    end
  end

  // Capture pad data into the tagged port and (re)start its valid hold window
  always_ff @(posedge clk_sram or posedge rst_sram) begin
    if (rst_sram) begin
      resp_vld_q <= '0;
      for (int p = 0; p < NPORTS; p++) begin
        resp_dat_q[p] <= '0;
        hold_cnt_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (rtag_q[RD_LAT-1][p]) begin
          resp_dat_q[p] <= bus.i_sram_dq;
          resp_vld_q[p] <= 1'b1;
          hold_cnt_q[p] <= 3'(RESP_HOLD - 1);
        end else if (resp_vld_q[p]) begin
          if (hold_cnt_q[p] == 3'd0) begin
            resp_vld_q[p] <= 1'b0;
          end else begin
            hold_cnt_q[p] <= hold_cnt_q[p] - 3'd1;
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_resp
    assign bus.o_resp_rdata[p*DW +: DW] = resp_dat_q[p];
  end

  assign bus.o_resp_valid = resp_vld_q;
  assign bus.o_sram_adr   = sram_adr_q;
  assign bus.o_sram_bw_n  = sram_bw_n_q;
  assign bus.o_sram_we_n  = sram_we_n_q;
  assign bus.o_sram_en_n  = sram_en_n_q;
  assign bus.o_sram_dq    = sram_dq_q;
  assign bus.o_sram_dq_oe = sram_dq_oe_q;
endmodule

// File: tb/tb_sram_arb_ctl.sv
// Scoreboard bench for sram_arb_ctl with a behavioural ZBT model.
// Latency: expected pin, write-data and response cycles are carried in the scoreboard entries.
// Backpressure: per-port drivers hold valid and fields until ready is seen.
module tb_sram_arb_ctl;
  localparam int NP     = 4;
  localparam int AW     = 18;
  localparam int DW     = 32;
  localparam int PAW    = 16;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  typedef struct packed {
    logic          we;
    logic [15:0]   adr;
    logic [17:0]   sadr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic [31:0]   exp_rd;
  } req_t;

  typedef struct packed { int cyc; logic [17:0] adr; logic we_n; logic [3:0] bw_n; } pin_t;
  typedef struct packed { int cyc; logic [31:0] dat; } wr_t;
  typedef struct packed { int cyc; int port; logic [31:0] dat; } resp_t;
  typedef struct packed { int cyc; logic vld; logic [31:0] dat; } h4_t;
  typedef struct packed { int cyc; logic [17:0] adr; } rd_t;
  typedef struct packed { logic [17:0] adr; logic [3:0] bw_n; } wp_t;

  logic clk_sram = 1'b0;
  logic rst_sram = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   resp_seen = 0;
  int   last_acc = -1;
  bit   b2b = 1'b0;

  req_t  req_q [NP][$];
  req_t  cur [NP];
  logic [NP-1:0] acc_pend;
  int    exp_grant_q[$];
  pin_t  pin_q[$];
  wr_t   wr_q[$];
  resp_t resp_q[$];
  h4_t   h4_q[$];
  rd_t   rd_pipe[$];
  wp_t   wr_pend[$];
  logic [31:0] mem [logic [17:0]];

  always #5 clk_sram = ~clk_sram;
  always @(posedge clk_sram) cyc <= cyc + 1;

  sram_arb_ctl_if #(.NPORTS(NP), .AW(AW), .DW(DW), .PAW(PAW)) bus ();
  sram_arb_ctl_if #(.NPORTS(NP), .AW(AW), .DW(DW), .PAW(PAW)) bus4 ();

  sram_arb_ctl #(.NPORTS(NP), .AW(AW), .DW(DW), .PARTITION(1), .PAW(PAW),
                 .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .RESP_HOLD(1)) u_dut (
    .clk_sram (clk_sram),
    .rst_sram (rst_sram),
    .bus      (bus.slave)
  );

  sram_arb_ctl #(.NPORTS(NP), .AW(AW), .DW(DW), .PARTITION(1), .PAW(PAW),
                 .RD_LAT(RD_LAT), .WR_LAT(WR_LAT), .RESP_HOLD(4)) u_dut_h4 (
    .clk_sram (clk_sram),
    .rst_sram (rst_sram),
    .bus      (bus4.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Unwritten SRAM locations read back a value derived from the address
  function automatic logic [31:0] dflt(input logic [17:0] a);
    return 32'hA5A5_0000 ^ {14'd0, a};
  endfunction

  function automatic bit pending();
    bit r = (exp_grant_q.size() != 0) || (pin_q.size() != 0) || (wr_q.size() != 0) ||
            (resp_q.size() != 0) || (|bus.i_req_valid);
    for (int p = 0; p < NP; p++) r = r || (req_q[p].size() != 0);
    return r;
  endfunction

  function automatic req_t rd(input logic [15:0] adr, input logic [17:0] sadr, input logic [31:0] exp);
    return '{we: 1'b0, adr: adr, sadr: sadr, wdata: 32'h0, be: 4'h0, exp_rd: exp};
  endfunction

  function automatic req_t wr(input logic [15:0] adr, input logic [17:0] sadr,
                              input logic [31:0] d, input logic [3:0] be);
    return '{we: 1'b1, adr: adr, sadr: sadr, wdata: d, be: be, exp_rd: 32'h0};
  endfunction

  // Record an accepted request and push everything the DUT owes for it
  task automatic accepted(input int p, input req_t r);
    if (exp_grant_q.size() == 0) begin
      check("grant_unexpected", 64'(p), 64'hFFFF);
    end else begin
      check("grant_port", 64'(p), 64'(exp_grant_q.pop_front()));
    end
    if (b2b && last_acc >= 0) check("grant_back_to_back", 64'(cyc), 64'(last_acc + 1));
    last_acc = cyc;
    pin_q.push_back('{cyc: cyc + 1, adr: r.sadr, we_n: ~r.we, bw_n: r.we ? ~r.be : 4'hF});
    if (r.we) wr_q.push_back('{cyc: cyc + 1 + WR_LAT, dat: r.wdata});
    else      resp_q.push_back('{cyc: cyc + RD_LAT + 2, port: p, dat: r.exp_rd});
  endtask

  // Per-port requesters: present queued requests, hold until ready
  initial begin : driver
    bus.i_req_valid = '0;
    bus.i_req_we    = '0;
    bus.i_req_adr   = '0;
    bus.i_req_wdata = '0;
    bus.i_req_be    = '0;
    acc_pend        = '0;
    forever begin
      @(negedge clk_sram);
      if (rst_sram) begin
        bus.i_req_valid = '0;
        acc_pend        = '0;
        continue;
      end
      for (int p = 0; p < NP; p++) begin
        if (acc_pend[p]) begin
          bus.i_req_valid[p] = 1'b0;
          acc_pend[p]        = 1'b0;
        end
        if (!bus.i_req_valid[p] && req_q[p].size() != 0) begin
          cur[p] = req_q[p].pop_front();
          bus.i_req_adr[p*PAW +: PAW] = cur[p].adr;
          bus.i_req_we[p]             = cur[p].we;
          bus.i_req_wdata[p*DW +: DW] = cur[p].wdata;
          bus.i_req_be[p*4 +: 4]      = cur[p].be;
          bus.i_req_valid[p]          = 1'b1;
        end
      end
      #1;
      if (|bus.i_req_valid) check("ready_onehot", 64'($onehot(bus.o_req_ready)), 64'd1);
      for (int p = 0; p < NP; p++) begin
        if (bus.i_req_valid[p] && bus.o_req_ready[p]) begin
          acc_pend[p] = 1'b1;
          accepted(p, cur[p]);
        end
      end
    end
  end

  // ZBT model: commands sampled on the pins, data merged/returned at fixed offsets
  initial begin : sram_model
    logic [31:0] tmp;
    wp_t w;
    rd_t r;
    bus.i_sram_dq = '0;
    forever begin
      @(negedge clk_sram);
      if (rst_sram) begin
        rd_pipe.delete();
        wr_pend.delete();
        bus.i_sram_dq = '0;
        continue;
      end
      if (bus.o_sram_dq_oe && wr_pend.size() != 0) begin
        w   = wr_pend.pop_front();
        tmp = mem.exists(w.adr) ? mem[w.adr] : dflt(w.adr);
        for (int b = 0; b < 4; b++) if (!w.bw_n[b]) tmp[8*b +: 8] = bus.o_sram_dq[8*b +: 8];
        mem[w.adr] = tmp;
      end
      if (!bus.o_sram_en_n) begin
        if (!bus.o_sram_we_n) wr_pend.push_back('{adr: bus.o_sram_adr, bw_n: bus.o_sram_bw_n});
        else                  rd_pipe.push_back('{cyc: cyc, adr: bus.o_sram_adr});
      end
      bus.i_sram_dq = 32'hBAD0_BAD0;
      if (rd_pipe.size() != 0 && rd_pipe[0].cyc + RD_LAT == cyc) begin
        r = rd_pipe.pop_front();
        bus.i_sram_dq = mem.exists(r.adr) ? mem[r.adr] : dflt(r.adr);
      end
    end
  end

  // Pin monitor: command and write-data cycles against the scoreboard
  initial begin : pin_mon
    pin_t pe;
    wr_t  we;
    forever begin
      @(negedge clk_sram);
      if (rst_sram) continue;
      if (!bus.o_sram_en_n) begin
        if (pin_q.size() == 0) begin
          check("pin_unexpected_issue", 64'(bus.o_sram_adr), 64'hFFFF_FFFF);
        end else begin
          pe = pin_q.pop_front();
          check("pin_cycle", 64'(cyc), 64'(pe.cyc));
          check("pin_adr", 64'(bus.o_sram_adr), 64'(pe.adr));
          check("pin_we_n", 64'(bus.o_sram_we_n), 64'(pe.we_n));
          check("pin_bw_n", 64'(bus.o_sram_bw_n), 64'(pe.bw_n));
        end
      end
      if (bus.o_sram_dq_oe) begin
        if (wr_q.size() == 0) begin
          check("dq_unexpected_oe", 64'(bus.o_sram_dq), 64'hFFFF_FFFF_FFFF);
        end else begin
          we = wr_q.pop_front();
          check("dq_cycle", 64'(cyc), 64'(we.cyc));
          check("dq_data", 64'(bus.o_sram_dq), 64'(we.dat));
        end
      end
    end
  end

  // Response monitor: RESP_HOLD=1, so every valid cycle is one response
  initial begin : resp_mon
    resp_t re;
    forever begin
      @(negedge clk_sram);
      if (rst_sram) continue;
      if (|bus.o_resp_valid) begin
        resp_seen++;
        if (resp_q.size() == 0) begin
          check("resp_unexpected", 64'(bus.o_resp_valid), 64'h0);
        end else begin
          re = resp_q.pop_front();
          check("resp_cycle", 64'(cyc), 64'(re.cyc));
          check("resp_valid_vec", 64'(bus.o_resp_valid), 64'(1) << re.port);
          check("resp_rdata", 64'(bus.o_resp_rdata[re.port*DW +: DW]), 64'(re.dat));
        end
      end
    end
  end

  // Monitor for the RESP_HOLD=4 instance, port 0
  initial begin : h4_mon
    h4_t he;
    forever begin
      @(negedge clk_sram);
      if (h4_q.size() != 0 && h4_q[0].cyc == cyc) begin
        he = h4_q.pop_front();
        check("hold4_valid0", 64'(bus4.o_resp_valid[0]), 64'(he.vld));
        check("hold4_rdata0", 64'(bus4.o_resp_rdata[31:0]), 64'(he.dat));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while (pending() && n < 300) begin
      @(negedge clk_sram);
      #2;
      n++;
    end
    check({name, "_drain"}, 64'(pending()), 64'd0);
    repeat (2) @(negedge clk_sram);
    #2;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"},   64'(bus.o_req_ready), 64'h0);
    check({name, "_rvalid"},  64'(bus.o_resp_valid), 64'h0);
    check({name, "_rdata"},   64'(|bus.o_resp_rdata), 64'h0);
    check({name, "_en_n"},    64'(bus.o_sram_en_n), 64'h1);
    check({name, "_we_n"},    64'(bus.o_sram_we_n), 64'h1);
    check({name, "_bw_n"},    64'(bus.o_sram_bw_n), 64'hF);
    check({name, "_adr"},     64'(bus.o_sram_adr), 64'h0);
    check({name, "_dq"},      64'(bus.o_sram_dq), 64'h0);
    check({name, "_dq_oe"},   64'(bus.o_sram_dq_oe), 64'h0);
  endtask

  initial begin : main
    int c0;
    int seen0;
    bus4.i_req_valid = '0;
    bus4.i_req_we    = '0;
    bus4.i_req_adr   = '0;
    bus4.i_req_wdata = '0;
    bus4.i_req_be    = '0;
    bus4.i_sram_dq   = '0;

    // Reset state
    repeat (3) @(negedge clk_sram);
    bus.i_req_valid = '0;
    #1;
    check_reset_outputs("rst_init");
    @(posedge clk_sram);
    #2 rst_sram = 1'b0;
    @(negedge clk_sram);
    #2;

    // Port 2 write then read, partitioned address 18'h21234
    req_q[2].push_back(wr(16'h1234, 18'h21234, 32'hDEADBEEF, 4'hF));
    req_q[2].push_back(rd(16'h1234, 18'h21234, 32'hDEADBEEF));
    exp_grant_q = '{2, 2};
    wait_idle("wr_rd_p2");

    // All ports reading; pointer sits at 3 after the last grant to port 2
    b2b = 1'b1;
    last_acc = -1;
    req_q[0].push_back(rd(16'h0100, 18'h00100, 32'hA5A50100));
    req_q[0].push_back(rd(16'h0104, 18'h00104, 32'hA5A50104));
    req_q[1].push_back(rd(16'h0100, 18'h10100, 32'hA5A40100));
    req_q[1].push_back(rd(16'h0104, 18'h10104, 32'hA5A40104));
    req_q[2].push_back(rd(16'h0100, 18'h20100, 32'hA5A70100));
    req_q[2].push_back(rd(16'h0104, 18'h20104, 32'hA5A70104));
    req_q[3].push_back(rd(16'h0100, 18'h30100, 32'hA5A60100));
    req_q[3].push_back(rd(16'h0104, 18'h30104, 32'hA5A60104));
    exp_grant_q = '{3, 0, 1, 2, 3, 0, 1, 2};
    wait_idle("rr_all");

    // Only ports 1 and 3: alternate with no idle pin cycles
    last_acc = -1;
    req_q[1].push_back(rd(16'h0200, 18'h10200, 32'hA5A40200));
    req_q[1].push_back(rd(16'h0204, 18'h10204, 32'hA5A40204));
    req_q[1].push_back(rd(16'h0208, 18'h10208, 32'hA5A40208));
    req_q[3].push_back(rd(16'h0200, 18'h30200, 32'hA5A60200));
    req_q[3].push_back(rd(16'h0204, 18'h30204, 32'hA5A60204));
    req_q[3].push_back(rd(16'h0208, 18'h30208, 32'hA5A60208));
    exp_grant_q = '{3, 1, 3, 1, 3, 1};
    wait_idle("rr_1_3");
    b2b = 1'b0;

    // Byte-lane write merge on port 0
    req_q[0].push_back(wr(16'h0040, 18'h00040, 32'hDEADBEEF, 4'hF));
    req_q[0].push_back(wr(16'h0040, 18'h00040, 32'h11223344, 4'b0101));
    req_q[0].push_back(rd(16'h0040, 18'h00040, 32'hDE22BE44));
    exp_grant_q = '{0, 0, 0};
    wait_idle("byte_lane");

    // RESP_HOLD=4 instance: two port-0 reads two cycles apart
    @(negedge clk_sram);
    c0 = cyc;
    for (int k = 6; k <= 13; k++) begin
      h4_q.push_back('{cyc: c0 + k, vld: (k <= 11), dat: (k <= 7) ? 32'h1111_1111 : 32'h2222_2222});
    end
    bus4.i_req_adr[15:0] = 16'h0010;
    bus4.i_req_valid[0]  = 1'b1;
    #1 check("hold4_ready_a", 64'(bus4.o_req_ready), 64'h1);
    @(negedge clk_sram);
    bus4.i_req_valid[0] = 1'b0;
    @(negedge clk_sram);
    bus4.i_req_adr[15:0] = 16'h0014;
    bus4.i_req_valid[0]  = 1'b1;
    #1 check("hold4_ready_b", 64'(bus4.o_req_ready), 64'h1);
    @(negedge clk_sram);
    bus4.i_req_valid[0] = 1'b0;
    @(negedge clk_sram);
    @(negedge clk_sram);
    bus4.i_sram_dq = 32'h1111_1111;
    @(negedge clk_sram);
    bus4.i_sram_dq = '0;
    @(negedge clk_sram);
    bus4.i_sram_dq = 32'h2222_2222;
    @(negedge clk_sram);
    bus4.i_sram_dq = '0;
    repeat (7) @(negedge clk_sram);
    #2;
    check("hold4_drain", 64'(h4_q.size()), 64'd0);

    // Reset with reads in flight; pointer is 1 after the byte-lane test
    req_q[1].push_back(rd(16'h0400, 18'h10400, 32'hA5A40400));
    req_q[2].push_back(rd(16'h0400, 18'h20400, 32'hA5A70400));
    req_q[3].push_back(rd(16'h0400, 18'h30400, 32'hA5A60400));
    exp_grant_q = '{1, 2};
    @(negedge clk_sram);
    @(negedge clk_sram);
    @(posedge clk_sram);
    #2 rst_sram = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    check("rst_mid_grants_seen", 64'(exp_grant_q.size()), 64'd0);
    for (int p = 0; p < NP; p++) req_q[p].delete();
    exp_grant_q.delete();
    pin_q.delete();
    wr_q.delete();
    resp_q.delete();
    repeat (3) @(posedge clk_sram);
    #2 rst_sram = 1'b0;
    seen0 = resp_seen;
    repeat (12) @(negedge clk_sram);
    #2;
    check("no_resp_after_reset", 64'(resp_seen - seen0), 64'd0);

    // Pointer restarts at 0: port 0 wins over port 3
    req_q[0].push_back(rd(16'h0300, 18'h00300, 32'hA5A50300));
    req_q[3].push_back(rd(16'h0300, 18'h30300, 32'hA5A60300));
    exp_grant_q = '{0, 3};
    wait_idle("ptr_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sram_arb_ctl.md
Name: sram_arb_ctl

Overview:
Parametrised N-port front-end and ZBT SRAM pin controller. It is the successor of the fixed 4-slot TDM SRAM controller. Each port has a valid/ready request interface. A work-conserving round-robin arbiter replaces fixed time slots, so idle ports cost no bandwidth. The block drives pipelined ZBT pins directly, with split data-bus pins (tristate in pad wrapper), and returns read data per port after a fixed, parameter-defined latency.

Parameters:
NPORTS, 4, number of request ports (1..8)
AW, 18, SRAM word address width
DW, 32, data width; BW=DW/8 byte lanes
PARTITION, 1, 1: SRAM addr = {port id (log2 NPORTS bits), port addr}; 0: SRAM addr = port addr
PAW, 16, port address width; must equal AW-log2(NPORTS) if PARTITION=1, else AW
RD_LAT, 4, cycles from address on pins to read data sampled on i_sram_dq (>=2)
WR_LAT, 2, cycles from address on pins to write data driven (>=1)
RESP_HOLD, 1, cycles o_resp_valid stays high per response (1..4)

Ports:
clk_sram in 1 clock
rst_sram in 1 async active-high reset
i_req_adr in NPORTS*PAW per-port word address, port p at [p*PAW +: PAW]
i_req_we in NPORTS 1=write, 0=read
i_req_wdata in NPORTS*DW write data
i_req_be in NPORTS*BW byte enables, active high
i_req_valid in NPORTS request valid
o_req_ready out NPORTS request accepted this cycle
o_resp_rdata out NPORTS*DW read data per port
o_resp_valid out NPORTS read response valid per port
o_sram_adr out AW SRAM address
o_sram_bw_n out BW byte write enables, active low
o_sram_we_n out 1 write enable, active low
o_sram_en_n out 1 chip enable, active low
o_sram_dq out DW write data to pad
o_sram_dq_oe out 1 pad output enable
i_sram_dq in DW read data from pad

Behaviour:
- Reset (async assert, sync release): o_req_ready=0, o_resp_valid=0, o_resp_rdata=0, o_sram_en_n=1, o_sram_we_n=1, o_sram_bw_n=all 1, o_sram_adr=0, o_sram_dq=0, o_sram_dq_oe=0; RR pointer=0; all pipelines cleared. In-flight reads at reset are dropped; no response is issued.
- Handshake: transfer when i_req_valid[p] & o_req_ready[p]. o_req_ready is combinational from i_req_valid and the pointer. Requesters must not make valid depend on ready. At most one ready bit is high per cycle. Once valid is raised, it and its fields are held until accepted.
- Arbitration: grant the first valid port scanning ptr, ptr+1, ..., wrapping mod NPORTS. On grant g, ptr <= (g+1) mod NPORTS. With no valid requests, ptr is unchanged. One access per cycle; back-to-back grants allowed; read/write mixing allowed with no bubble (ZBT).
- Issue (cycle A = accept+1): registered pins. en_n=0, we_n=~we, adr per PARTITION. bw_n=~be for writes, all 1 for reads. Idle cycle: en_n=1, we_n=1, bw_n=all 1.
- Write data: o_sram_dq=wdata with o_sram_dq_oe=1 exactly at cycle A+WR_LAT. oe=0 otherwise.
- Read return: a one-hot port tag shift register of depth RD_LAT. i_sram_dq is registered at A+RD_LAT. At A+RD_LAT+1, o_resp_rdata[p] updates and o_resp_valid[p] rises. Total read latency is RD_LAT+2 cycles from accept.
- o_resp_rdata[p] holds its value until that port's next response. Other ports' data are unaffected.
- Response hold: o_resp_valid[p] stays high RESP_HOLD cycles. If a new response for p arrives during the hold, data updates and the hold counter restarts. Each response counts as one, provided requesters space reads to the same port >= RESP_HOLD apart. With RESP_HOLD=1, back-to-back reads to one port give consecutive one-cycle pulses.
- Responses return in issue order. Responses to different ports may occur in the same cycle only with RESP_HOLD>1 overlap; they are never issued simultaneously.
- NPORTS=1: the arbiter degenerates to ready=valid. The port-id field is zero-width and PARTITION is ignored.

Test Plan:
- Reset defaults: assert rst_sram mid-stream with reads in flight -> all outputs at reset values immediately; no o_resp_valid after release; en_n=1, bw_n=4'hF.
- Single write then read, port 2, PARTITION=1, adr=16'h1234, wdata=32'hDEADBEEF, be=4'hF -> o_sram_adr=18'h21234, dq_oe high 2 cycles after write issue. Read returns 32'hDEADBEEF with o_resp_valid[2] 6 cycles after accept (RD_LAT=4).
- All 4 ports valid continuously with reads -> grants 0,1,2,3,0,... one per cycle. Each port gets exactly 1/4 of cycles. Responses in grant order.
- Only port 1 and port 3 valid -> alternate grants 1,3,1,3 with no idle pin cycles (work-conserving).
- Byte-lane write be=4'b0101 -> o_sram_bw_n=4'b1010 for one cycle. A following read of the same address returns the merged data from the SRAM model.
- RESP_HOLD=4, two reads to port 0 spaced 2 cycles apart -> o_resp_valid[0] high 6 cycles. rdata switches to the second value at the second response.
